// File: rtl/sdram_init.sv
// SDRAM power-up sequencer: clock wait, PRECHARGE ALL, AUTO REFRESH xN, LOAD MODE, then ofin.
// Optional macro SDRAM_INIT_AUTOSTART_EN starts the sequence on the first edge out of reset.
module sdram_init #(
  parameter int unsigned INIT_WAIT     = 20000,
  parameter int unsigned T_RP          = 3,
  parameter int unsigned T_RFC         = 9,
  parameter int unsigned T_MRD         = 2,
  parameter int unsigned REFRESH_COUNT = 2,
  parameter logic [12:0] MODE_REG      = 13'h0220
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        ienb,
  output logic        ofin,
  output logic        obusy,
  output logic        DRAM_CKE,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_CS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N,
  output logic        DRAM_LDQM,
  output logic        DRAM_UDQM
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WAIT     = 4'd1;
  localparam logic [3:0] S_PRE      = 4'd2;
  localparam logic [3:0] S_WAIT_RP  = 4'd3;
  localparam logic [3:0] S_REF      = 4'd4;
  localparam logic [3:0] S_WAIT_RFC = 4'd5;
  localparam logic [3:0] S_LMR      = 4'd6;
  localparam logic [3:0] S_WAIT_MRD = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  localparam logic [3:0] CMD_IDLE = 4'b1111;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  logic [3:0]  state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [3:0]  ref_cnt, ref_nx;
  logic        start;

`ifdef SDRAM_INIT_AUTOSTART_EN
  logic unused_ienb;
  assign unused_ienb = ienb;
  assign start = 1'b1;
`else
  assign start = ienb;
`endif

  // Wait states are entered with the count minus one for the command cycle, and skipped when that is zero.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ref_nx   = ref_cnt;
    case (state)
      S_IDLE: if (start) begin
        state_nx = S_WAIT;
        cnt_nx   = 16'(INIT_WAIT - 1);
      end
      S_WAIT: if (cnt == '0) state_nx = S_PRE; else cnt_nx = cnt - 16'd1;
      S_PRE: if (T_RP > 1) begin
        state_nx = S_WAIT_RP;
        cnt_nx   = 16'(T_RP - 2);
      end else state_nx = S_REF;
      S_WAIT_RP: if (cnt == '0) state_nx = S_REF; else cnt_nx = cnt - 16'd1;
      S_REF: begin
        ref_nx = ref_cnt + 4'd1;
        if (T_RFC > 1) begin
          state_nx = S_WAIT_RFC;
          cnt_nx   = 16'(T_RFC - 2);
        end else if (ref_nx == 4'(REFRESH_COUNT)) state_nx = S_LMR;
        else state_nx = S_REF;
      end
      S_WAIT_RFC: if (cnt == '0) begin
        state_nx = (ref_cnt == 4'(REFRESH_COUNT)) ? S_LMR : S_REF;
      end else cnt_nx = cnt - 16'd1;
      S_LMR: if (T_MRD > 1) begin
        state_nx = S_WAIT_MRD;
        cnt_nx   = 16'(T_MRD - 2);
      end else state_nx = S_DONE;
      S_WAIT_MRD: if (cnt == '0) state_nx = S_DONE; else cnt_nx = cnt - 16'd1;
      S_DONE: state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  logic        cke_d, dqm_d, fin_d, busy_d;
  logic [3:0]  cmd_d;
  logic [12:0] addr_d;
  logic [1:0]  ba_d;

  // Pin values are decoded from the next state so they appear in the same cycle the state is entered.
  always_comb begin
    cke_d  = 1'b1;
    cmd_d  = CMD_NOP;
    addr_d = '0;
    ba_d   = '0;
    dqm_d  = 1'b1;
    fin_d  = 1'b0;
    busy_d = 1'b1;
    case (state_nx)
      S_IDLE: begin
        cke_d  = 1'b0;
        cmd_d  = CMD_IDLE;
        busy_d = 1'b0;
      end
      S_PRE: begin
        cmd_d      = CMD_PRE;
        addr_d[10] = 1'b1;
      end
      S_REF: cmd_d = CMD_REF;
      S_LMR: begin
        cmd_d  = CMD_LMR;
        addr_d = MODE_REG;
      end
      S_DONE: begin
        dqm_d  = 1'b0;
        fin_d  = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ref_cnt    <= '0;
      ofin       <= 1'b0;
      obusy      <= 1'b0;
      DRAM_CKE   <= 1'b0;
      DRAM_ADDR  <= '0;
      DRAM_BA    <= '0;
      {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} <= CMD_IDLE;
      DRAM_LDQM  <= 1'b1;
      DRAM_UDQM  <= 1'b1;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      ref_cnt    <= ref_nx;
      ofin       <= fin_d;
      obusy      <= busy_d;
      DRAM_CKE   <= cke_d;
      DRAM_ADDR  <= addr_d;
      DRAM_BA    <= ba_d;
      {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} <= cmd_d;
      DRAM_LDQM  <= dqm_d;
      DRAM_UDQM  <= dqm_d;
    end
  end

endmodule

// File: tb/tb_sdram_init.sv
// Bench for sdram_init: two parameter sets driven in lockstep, checked against a cycle-timeline model.
// Honours SDRAM_INIT_AUTOSTART_EN when the design is built with it.
module tb_sdram_init;

`ifdef SDRAM_INIT_AUTOSTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // Pin vector: {CKE, CS,RAS,CAS,WE, ADDR[12:0], BA[1:0], LDQM,UDQM, ofin, obusy}
  localparam logic [23:0] P_IDLE = {1'b0, 4'b1111, 13'h0000, 2'b00, 2'b11, 1'b0, 1'b0};
  localparam logic [23:0] P_NOP  = {1'b1, 4'b0111, 13'h0000, 2'b00, 2'b11, 1'b0, 1'b1};
  localparam logic [23:0] P_PRE  = {1'b1, 4'b0010, 13'h0400, 2'b00, 2'b11, 1'b0, 1'b1};
  localparam logic [23:0] P_REF  = {1'b1, 4'b0001, 13'h0000, 2'b00, 2'b11, 1'b0, 1'b1};
  localparam logic [23:0] P_LMR  = {1'b1, 4'b0000, 13'h0220, 2'b00, 2'b11, 1'b0, 1'b1};
  localparam logic [23:0] P_DONE = {1'b1, 4'b0111, 13'h0000, 2'b00, 2'b00, 1'b1, 1'b0};

  logic iclk = 1'b0;
  logic ireset = 1'b1;
  logic ienb = 1'b0;
  always #5 iclk = ~iclk;

  logic        fin1, busy1, cke1, cs1, ras1, cas1, we1, ldqm1, udqm1;
  logic [12:0] addr1;
  logic [1:0]  ba1;
  logic        fin2, busy2, cke2, cs2, ras2, cas2, we2, ldqm2, udqm2;
  logic [12:0] addr2;
  logic [1:0]  ba2;

  sdram_init #(.INIT_WAIT(10), .T_RP(2), .T_RFC(4), .T_MRD(2), .REFRESH_COUNT(2), .MODE_REG(13'h0220)) u_dut1 (
    .iclk(iclk), .ireset(ireset), .ienb(ienb), .ofin(fin1), .obusy(busy1),
    .DRAM_CKE(cke1), .DRAM_ADDR(addr1), .DRAM_BA(ba1),
    .DRAM_CS_N(cs1), .DRAM_RAS_N(ras1), .DRAM_CAS_N(cas1), .DRAM_WE_N(we1),
    .DRAM_LDQM(ldqm1), .DRAM_UDQM(udqm1));

  sdram_init #(.INIT_WAIT(10), .T_RP(1), .T_RFC(4), .T_MRD(2), .REFRESH_COUNT(4), .MODE_REG(13'h0220)) u_dut2 (
    .iclk(iclk), .ireset(ireset), .ienb(ienb), .ofin(fin2), .obusy(busy2),
    .DRAM_CKE(cke2), .DRAM_ADDR(addr2), .DRAM_BA(ba2),
    .DRAM_CS_N(cs2), .DRAM_RAS_N(ras2), .DRAM_CAS_N(cas2), .DRAM_WE_N(we2),
    .DRAM_LDQM(ldqm2), .DRAM_UDQM(udqm2));

  logic [23:0] pins1, pins2;
  assign pins1 = {cke1, cs1, ras1, cas1, we1, addr1, ba1, ldqm1, udqm1, fin1, busy1};
  assign pins2 = {cke2, cs2, ras2, cas2, we2, addr2, ba2, ldqm2, udqm2, fin2, busy2};

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  int rel = 0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Expected pins from the command timeline measured from the start edge.
  function automatic logic [23:0] model(input bit st, input int r, input int iw, input int rp,
                                        input int rfc, input int mrd, input int rc);
    int l;
    l = iw + rp + rc * rfc;
    if (!st) return P_IDLE;
    if (r >= l + mrd) return P_DONE;
    if (r == iw) return P_PRE;
    if (r == l) return P_LMR;
    if (r >= iw + rp && r < l && ((r - iw - rp) % rfc) == 0) return P_REF;
    return P_NOP;
  endfunction

  task automatic step(input logic r, input logic e);
    ireset = r;
    ienb   = e;
    @(posedge iclk);
    if (r) begin
      started = 1'b0;
      rel     = 0;
    end else if (!started && (AUTO || e)) begin
      started = 1'b1;
      rel     = 0;
    end else if (started) begin
      rel++;
    end
    #1;
    check("dut1_model", pins1, model(started, rel, 10, 2, 4, 2, 2));
    check("dut2_model", pins2, model(started, rel, 10, 1, 4, 2, 4));
  endtask

  typedef struct {
    int          rel;
    bit          dut2;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{0,  1'b0, P_NOP});  tbl.push_back('{9,  1'b0, P_NOP});
    tbl.push_back('{10, 1'b0, P_PRE});  tbl.push_back('{11, 1'b0, P_NOP});
    tbl.push_back('{12, 1'b0, P_REF});  tbl.push_back('{13, 1'b0, P_NOP});
    tbl.push_back('{16, 1'b0, P_REF});  tbl.push_back('{17, 1'b0, P_NOP});
    tbl.push_back('{20, 1'b0, P_LMR});  tbl.push_back('{21, 1'b0, P_NOP});
    tbl.push_back('{22, 1'b0, P_DONE}); tbl.push_back('{30, 1'b0, P_DONE});
    tbl.push_back('{32, 1'b0, P_DONE});
    tbl.push_back('{10, 1'b1, P_PRE});  tbl.push_back('{11, 1'b1, P_REF});
    tbl.push_back('{12, 1'b1, P_NOP});  tbl.push_back('{15, 1'b1, P_REF});
    tbl.push_back('{19, 1'b1, P_REF});  tbl.push_back('{23, 1'b1, P_REF});
    tbl.push_back('{24, 1'b1, P_NOP});  tbl.push_back('{27, 1'b1, P_LMR});
    tbl.push_back('{28, 1'b1, P_NOP});  tbl.push_back('{29, 1'b1, P_DONE});

    // Reset held three cycles, then idle with ienb low.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check("reset_pins", pins1, P_IDLE);
    end
`ifndef SDRAM_INIT_AUTOSTART_EN
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      check("idle_hold", pins1, P_IDLE);
    end
`endif

    // Main timeline with stray ienb pulses mid-sequence and after completion.
    for (int r = 0; r <= 32; r++) begin
      step(1'b0, ((r == 0) && !AUTO) || r == 5 || r == 30);
      foreach (tbl[j]) begin
        if (tbl[j].rel == r) begin
          if (tbl[j].dut2) check("table_dut2", pins2, tbl[j].exp);
          else check("table_dut1", pins1, tbl[j].exp);
        end
      end
    end

    // Abort between the two refreshes, then restart with a fresh ienb.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int a = 0; a <= 44; a++) begin
      step(a == 15, ((a == 0) || (a == 20)) && !AUTO);
      if (a == 15) check("abort_idle", pins1, P_IDLE);
`ifndef SDRAM_INIT_AUTOSTART_EN
      if (a == 30) check("restart_pre", pins1, P_PRE);
      if (a == 41) check("restart_prefin", pins1, P_NOP);
      if (a == 42) check("restart_fin", pins1, P_DONE);
`endif
    end

    // Random resets and start pulses against the timeline model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_init.md
# sdram_init

Power-up initialisation sequencer for the external SDRAM. It sits directly upstream of `sdram_read` and owns the DRAM command pins until the device is usable. On a start request it runs the JEDEC power-up sequence:

- stable-clock wait;
- PRECHARGE ALL;
- a number of AUTO REFRESH commands;
- LOAD MODE REGISTER.

It then raises `ofin`, which the top level uses to hand the DRAM pins to the read/write path.

## Interface
Parameters:
- INIT_WAIT, 20000, NOP cycles after start before PRECHARGE (100 us at 200 MHz); range 1..65535
- T_RP, 3, cycles from PRECHARGE to the next command; ≥1
- T_RFC, 9, cycles from each AUTO REFRESH to the next command; ≥1
- T_MRD, 2, cycles from LOAD MODE to `ofin` high; ≥1
- REFRESH_COUNT, 2, number of AUTO REFRESH commands; 1..15
- MODE_REG, 13'h0220, value driven on DRAM_ADDR during LOAD MODE (burst length 1, sequential, CAS latency 2, single-location write)

Ports:
- iclk  in  1  system clock; all logic on the rising edge
- ireset  in  1  reset; synchronous, active-high
- ienb  in  1  start request, sampled only in IDLE
- ofin  out  1  init complete; held high until reset
- obusy  out  1  high while the sequence is running (not IDLE, not DONE)
- DRAM_CKE  out  1  clock enable
- DRAM_ADDR  out  13  address / mode bus
- DRAM_BA  out  2  bank address
- DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  out  1 each  command pins
- DRAM_LDQM, DRAM_UDQM  out  1 each  data masks

## Operation
- Every output is registered and derived from the current state and counter.
- Command encodings (CS,RAS,CAS,WE):
  - NOP = 0111
  - PRECHARGE = 0010, with ADDR[10]=1 (all banks)
  - AUTO REFRESH = 0001
  - LOAD MODE = 0000, with ADDR = MODE_REG and BA = 0
- Each command is driven for exactly one cycle; NOP is driven in every other cycle.
- States:
  - IDLE: CKE=0, NOP. Moves to WAIT when ienb=1.
  - WAIT: CKE=1. Lasts INIT_WAIT cycles.
  - PRE: one cycle.
  - WAIT_RP: T_RP−1 cycles; skipped if T_RP=1.
  - REF: one cycle.
  - WAIT_RFC: T_RFC−1 cycles. Returns to REF until REFRESH_COUNT refreshes have been issued, then goes to LMR.
  - LMR: one cycle.
  - WAIT_MRD: T_MRD−1 cycles.
  - DONE: terminal state.
- In DONE: CKE=1, NOP, ADDR=0, BA=0, DQM=0, ofin=1. The block stays there until reset.
- DQM is 1 in every state except DONE.
- Delay counter: 16 bits, loaded on state entry and decremented to 0. Refresh counter: 4 bits.
- ienb is ignored in every state except IDLE, including pulses arriving mid-sequence or after DONE.

## Timing
Cycle 0 is the clock edge at which ienb=1 is sampled in IDLE. A command or output "at cycle N" is visible on the pins immediately after edge N.
- WAIT is entered and CKE=1 at cycle 0.
- PRECHARGE at cycle INIT_WAIT.
- AUTO REFRESH number k (k = 0..REFRESH_COUNT−1) at cycle INIT_WAIT + T_RP + k·T_RFC.
- LOAD MODE at cycle L = INIT_WAIT + T_RP + REFRESH_COUNT·T_RFC.
- ofin rises and obusy falls at cycle L + T_MRD. With defaults this is cycle 20023.

Reset behaviour:
- Values while ireset is sampled high, and after it: state IDLE, ofin=0, obusy=0, CKE=0, CS/RAS/CAS/WE=1, ADDR=0, BA=0, LDQM=UDQM=1, counters 0.
- Reset asserted mid-sequence, including during a command cycle, aborts at the next edge.
- After such an abort, a restart needs ireset low and a fresh ienb. The sequence then restarts from WAIT with the full INIT_WAIT.
- If ireset and ienb are high on the same edge, reset wins and the block stays in IDLE.

## Configuration
- SDRAM_INIT_AUTOSTART_EN defined:
  - IDLE moves to WAIT on the first edge with ireset low; ienb is ignored entirely.
  - Cycle 0 is defined as that edge.
- SDRAM_INIT_AUTOSTART_EN undefined: the block waits in IDLE for ienb as described above.

## Test plan
All scenarios use INIT_WAIT=10, T_RP=2, T_RFC=4, T_MRD=2, REFRESH_COUNT=2 unless stated otherwise.
- Reset held for 3 cycles, ienb low → all outputs at their reset values; IDLE holds indefinitely; CKE=0.
- ienb pulse at cycle 0 → PRE with ADDR[10]=1 at cycle 10; REF at 12 and 16; LOAD MODE with ADDR=0x0220 at 20; ofin=1 at 22; NOP in every other cycle; DQM=1 until 22, then 0.
- Reset at cycle 14 (between the two REFs) → IDLE at the next edge, ofin=0. A new ienb at cycle 20 gives PRE at 30 and ofin at 42.
- Extra ienb pulses at cycles 5 and 30 → no change to the command timeline; ofin stays 1.
- REFRESH_COUNT=4, T_RP=1 → PRE at 10; REF at 11, 15, 19, 23; LOAD MODE at 27; ofin at 29.
- Built with SDRAM_INIT_AUTOSTART_EN, ienb held 0, reset released at edge 0 → PRE at 10; ofin at 22.
